// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands, issues them one at a time to a
// registered 4-bit ALU, and checks each result against a golden model.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int ERRW  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [10:0]     cmd_data,
    output logic [3:0]      alu_a,
    output logic [3:0]      alu_b,
    output logic [2:0]      alu_op,
    output logic            alu_ena,
    input  logic [3:0]      alu_result,
    input  logic            alu_carry,
    input  logic            alu_parity,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [6:0]      rsp_data,
    output logic [ERRW-1:0] err_count,
    output logic            busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        PUSH    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [10:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            full_q;
    logic            push, pop, load;
    logic [10:0]     head;
    logic [3:0]      a_q, b_q;
    logic [2:0]      op_q;
    logic            ena_q;
    logic [5:0]      hold_q;
    logic [4:0]      exp_w;
    logic            mismatch;
    logic            rsp_valid_q;
    logic [6:0]      rsp_data_q;
    logic [ERRW-1:0] err_q;

    assign head      = mem_q[rd_ptr_q];
    assign push      = cmd_valid && !full_q;
    assign cmd_ready = !full_q;
    assign cnt_d     = cnt_q + CW'(push) - CW'(pop);

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign alu_ena   = ena_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign err_count = err_q;
    assign busy      = (state_q != IDLE) || (cnt_q != '0);

    // command storage; contents are don't-care until counted valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_data;
        end
    end

    // FIFO pointers, occupancy and registered full flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == FULL_CNT);
        end
    end

    // sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state plus pop/load strobes
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cnt_q != '0) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = PUSH;
            PUSH: begin
                if (!rsp_valid_q || rsp_ready) begin
                    load    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // operand register doubles as ALU drive; ena pulses during ISSUE
    // and the ALU outputs are grabbed on the edge closing CAPTURE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            ena_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            ena_q <= pop;
            if (pop) begin
                a_q  <= head[3:0];
                b_q  <= head[7:4];
                op_q <= head[10:8];
            end
            if (state_q == CAPTURE) begin
                hold_q <= {alu_parity, alu_carry, alu_result};
            end
        end
    end

    // golden {carry, result} from the operand register
    always_comb begin
        exp_w = 5'd0;
        unique case (op_q)
            3'd0: exp_w = {1'b0, a_q} + {1'b0, b_q};
            3'd1: exp_w = {1'b0, a_q} - {1'b0, b_q};
            3'd2: exp_w = {1'b0, a_q & b_q};
            3'd3: exp_w = {1'b0, a_q | b_q};
            3'd4: exp_w = {1'b0, a_q ^ b_q};
            3'd5: exp_w = {1'b0, ~(a_q | b_q)};
            3'd6: exp_w = {1'b0, ~a_q};
            3'd7: exp_w = {1'b0, b_q};
        endcase
    end

    assign mismatch = (hold_q[3:0] != exp_w[3:0])
                   || (hold_q[4] != exp_w[4])
                   || (hold_q[5] != ^exp_w[3:0]);

    // response register and saturating mismatch counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= '0;
        end else begin
            if (load) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= {mismatch, hold_q};
                if (mismatch && (err_q != '1)) begin
                    err_q <= err_q + ERRW'(1);
                end
            end else if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

endmodule
